agex_muldiv_ctrl: RTL and testbench

- Iterative sequencer for RV32M multiply/divide, attached beside the AGEX ALU.
- Accepts one M-extension op at a time through a valid/ready handshake.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, then returns the result with its destination tag.
- Drives busy so the pipeline can hold DE/AGEX while an op is in flight. Honours branch-redirect flush.

---
 rtl/agex_muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_agex_muldiv_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/agex_muldiv_ctrl.sv
// ============================================================================
// Module   : agex_muldiv_ctrl
// Brief    : Iterative RV32M multiply/divide sequencer beside the AGEX ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module agex_muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_op,
    input  logic [XLEN-1:0] i_req_a,
    input  logic [XLEN-1:0] i_req_b,
    input  logic [TAGW-1:0] i_req_tag,
    input  logic            i_flush,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_res_data,
    output logic [TAGW-1:0] o_res_tag,
    output logic            o_busy
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [TAGW-1:0]     r_tag;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN:0]     r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_neg_p;
    logic                r_neg_r;
    logic                r_special;
    logic [XLEN-1:0]     r_res_data;
    logic [TAGW-1:0]     r_res_tag;

    logic                w_accept;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_add_hi;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic                w_ge;
    logic [2*XLEN:0]     w_acc_step;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quot_s;
    logic [XLEN-1:0]     w_rem_s;
    logic [XLEN-1:0]     w_fix_res;

    assign w_accept   = (r_state == S_IDLE) && i_req_valid && !i_flush;
    assign w_is_div   = r_op[2];
    assign w_a_signed = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_b_signed = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_a_neg    = w_a_signed && r_a[XLEN-1];
    assign w_b_neg    = w_b_signed && r_b[XLEN-1];
    assign w_mag_a    = w_a_neg ? -r_a : r_a;
    assign w_mag_b    = w_b_neg ? -r_b : r_b;

    assign w_div_zero    = w_is_div && (r_b == '0);
    assign w_ovf         = ((r_op == 3'b100) || (r_op == 3'b110)) && (r_a == MIN_INT) && (r_b == '1);
    assign w_special_res = w_div_zero ? (r_op[1] ? r_a : '1) : (r_op[1] ? '0 : MIN_INT);

    // Shared accumulator: multiply keeps {partial sum, multiplier}, divide keeps {remainder, quotient}.
    assign w_add_hi = r_acc[0] ? (r_acc[2*XLEN:XLEN] + {1'b0, r_opnd}) : r_acc[2*XLEN:XLEN];
    assign w_shift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_opnd};
    assign w_ge     = (w_shift >= {1'b0, r_opnd});

    assign w_acc_step = w_is_div ? {(w_ge ? w_diff : w_shift), r_acc[XLEN-2:0], w_ge}
                                 : {1'b0, w_add_hi, r_acc[XLEN-1:1]};

    assign w_prod_s = r_neg_p ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    assign w_quot_s = r_neg_p ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_s  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quot_s;
            default:                w_fix_res = w_rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Special results skip RUN but still pass through FIX so their latency is fixed at two.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
            S_PREP: w_next = (w_div_zero || w_ovf) ? S_FIX : S_RUN;
            S_RUN:  if (r_count == CNT_W'(XLEN-1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (i_res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_neg_p    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_res_data <= '0;
            r_res_tag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= i_req_op;
                        r_a   <= i_req_a;
                        r_b   <= i_req_b;
                        r_tag <= i_req_tag;
                    end
                end
                S_PREP: begin
                    r_neg_p   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    r_count   <= '0;
                    r_special <= w_div_zero || w_ovf;
                    r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
                    r_acc     <= {{(XLEN+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    if (w_div_zero || w_ovf) begin
                        r_res_data <= w_special_res;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count + CNT_W'(1);
                end
                S_FIX: begin
                    r_res_tag <= r_tag;
                    if (!r_special) begin
                        r_res_data <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_res_valid = (r_state == S_DONE);
    assign o_res_data  = r_res_data;
    assign o_res_tag   = r_res_tag;

endmodule

`default_nettype wire

// File: tb/tb_agex_muldiv_ctrl.sv
// ============================================================================
// Module   : tb_agex_muldiv_ctrl
// Brief    : Directed plus randomized bench for agex_muldiv_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_agex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_op;
    logic [31:0] i_req_a;
    logic [31:0] i_req_b;
    logic [4:0]  i_req_tag;
    logic        i_flush;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_data;
    logic [4:0]  o_res_tag;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agex_muldiv_ctrl #(.XLEN(32), .TAGW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_op    (i_req_op),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_tag   (i_req_tag),
        .i_flush     (i_flush),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_res_tag   (o_res_tag),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M results from 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Called at 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int hold);
        int          lat;
        logic        busy_bad;
        logic        stable_bad;
        logic [31:0] exp;
        exp        = model(op, a, b);
        busy_bad   = 1'b0;
        stable_bad = 1'b0;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_a     = a;
        i_req_b     = b;
        i_req_tag   = tag;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        lat = 0;
        while (!o_res_valid && lat < 60) begin
            if (o_busy !== 1'b1 || o_req_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
        chk({name, " data"}, o_res_data, exp);
        chk({name, " tag"}, {27'd0, o_res_tag}, {27'd0, tag});
        chk({name, " busy_held"}, {31'd0, busy_bad}, 32'd0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                if (o_res_valid !== 1'b1 || o_res_data !== exp || o_res_tag !== tag) stable_bad = 1'b1;
            end
            chk({name, " stable"}, {31'd0, stable_bad}, 32'd0);
        end
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
        chk({name, " ready_after"}, {31'd0, o_req_ready}, 32'd1);
        chk({name, " valid_after"}, {31'd0, o_res_valid}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        seen_valid;

        rst_n       = 1'b0;
        i_req_valid = 1'b0;
        i_req_op    = 3'd0;
        i_req_a     = 32'd0;
        i_req_b     = 32'd0;
        i_req_tag   = 5'd0;
        i_flush     = 1'b0;
        i_res_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("rst res_data", o_res_data, 32'd0);
        chk("rst res_tag", {27'd0, o_res_tag}, 32'd0);
        chk("rst busy", {31'd0, o_busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst req_ready", {31'd0, o_req_ready}, 32'd1);

        run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd9,  0);
        run_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  0);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  0);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  0);
        run_op("divu",      3'd5, 32'd100,        32'd7,         5'd4,  0);
        run_op("remu",      3'd7, 32'd100,        32'd7,         5'd5,  0);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  0);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  0);
        run_op("div_zero",  3'd4, 32'd5,          32'd0,         5'd8,  0);
        run_op("remu_zero", 3'd7, 32'd5,          32'd0,         5'd10, 0);
        run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 0);
        run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 0);
        run_op("backpress", 3'd1, 32'h1234_5678,  32'h9ABC_DEF0, 5'd13, 10);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 5'($urandom), (i % 8 == 0) ? 3 : 0);
        end

        // Flush while RUN holds count 10.
        i_req_valid = 1'b1;
        i_req_op    = 3'd5;
        i_req_a     = 32'd1000;
        i_req_b     = 32'd3;
        i_req_tag   = 5'd20;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("flush pre busy", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush busy", {31'd0, o_busy}, 32'd0);
        chk("flush req_ready", {31'd0, o_req_ready}, 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_res_valid !== 1'b0) seen_valid = 1'b1;
        end
        chk("flush no_result", {31'd0, seen_valid}, 32'd0);

        // Request coinciding with flush in IDLE is refused.
        i_req_valid = 1'b1;
        i_flush     = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
        chk("flush_req busy", {31'd0, o_busy}, 32'd0);
        run_op("post_flush", 3'd0, 32'd6, 32'd7, 5'd21, 0);

        // Asynchronous reset between edges in the middle of RUN.
        i_req_valid = 1'b1;
        i_req_op    = 3'd0;
        i_req_a     = 32'd123;
        i_req_b     = 32'd456;
        i_req_tag   = 5'd22;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async busy", {31'd0, o_busy}, 32'd0);
        chk("async res_valid", {31'd0, o_res_valid}, 32'd0);
        chk("async res_data", o_res_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd23, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
